// File: rtl/palette_engine.sv
`default_nettype none
// ============================================================================
// Module      : palette_engine
// Description : Banked colour palette lookup with a 2-stage pipeline,
//               double-buffered bank switching, frame-paced fade and a
//               palette clear sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module palette_engine #(
    parameter int INDEX_W     = 6,
    parameter int CH_W        = 4,
    parameter int BANKS       = 2,
    parameter int FADE_PERIOD = 4,
    localparam int BW         = $clog2(BANKS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                pix_valid,
    input  logic [INDEX_W-1:0]  pix_index,
    output logic                rgb_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    input  logic                wr_en,
    input  logic [BW-1:0]       wr_bank,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0]   wr_rgb,
    input  logic                bank_req,
    input  logic [BW-1:0]       bank_sel,
    output logic [BW-1:0]       active_bank,
    input  logic                fade_out_req,
    input  logic                fade_in_req,
    output logic [CH_W-1:0]     fade_level,
    output logic                fade_busy,
    output logic                fade_done,
    output logic                init_done
);

    localparam int ADDR_W = BW + INDEX_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = (FADE_PERIOD > 1) ? $clog2(FADE_PERIOD) : 1;

    localparam logic [CNT_W-1:0]  C_CNT_LAST   = CNT_W'(FADE_PERIOD - 1);
    localparam logic [CH_W-1:0]   C_LEVEL_MAX  = '1;
    localparam logic [CH_W-1:0]   C_LEVEL_PEN  = C_LEVEL_MAX - CH_W'(1);
    localparam logic [CH_W-1:0]   C_LEVEL_ONE  = CH_W'(1);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST  = '1;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_FADE_OUT = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_addr;
    logic                r_init_done;
    logic [CH_W-1:0]     r_fade_level;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic                r_fade_done;
    logic [BW-1:0]       r_pending_bank;
    logic [BW-1:0]       r_active_bank;
    logic [3*CH_W-1:0]   r_mem [0:DEPTH-1];
    logic                r_s1_valid;
    logic [3*CH_W-1:0]   r_s1_rgb;
    logic                r_rgb_valid;
    logic [CH_W-1:0]     r_red;
    logic [CH_W-1:0]     r_green;
    logic [CH_W-1:0]     r_blue;

    logic                w_s1_go;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [CH_W-1:0]     w_r_in;
    logic [CH_W-1:0]     w_g_in;
    logic [CH_W-1:0]     w_b_in;
    logic                w_step;

    // Lookups only start once the clear sweep is over; bank comes from the
    // registered active bank so a switch lands cleanly between frames.
    assign w_s1_go   = pix_valid && r_init_done;
    assign w_rd_addr = {r_active_bank, pix_index};
    assign w_r_in    = r_s1_rgb[3*CH_W-1 -: CH_W];
    assign w_g_in    = r_s1_rgb[2*CH_W-1 -: CH_W];
    assign w_b_in    = r_s1_rgb[CH_W-1:0];
    assign w_step    = frame_start && (r_frame_cnt == C_CNT_LAST);

    // Palette storage: the clear sweep owns the write port during INIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_init_addr] <= '0;
            end else if (wr_en && r_init_done) begin
                r_mem[{wr_bank, wr_index}] <= wr_rgb;
            end
        end
    end

    // Two-stage lookup pipeline: stage 1 reads, stage 2 applies the fade.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_rgb    <= '0;
            r_rgb_valid <= 1'b0;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
        end else begin
            r_s1_valid  <= w_s1_go;
            r_s1_rgb    <= w_s1_go ? r_mem[w_rd_addr] : '0;
            r_rgb_valid <= r_s1_valid;
            r_red       <= (r_s1_valid && (w_r_in > r_fade_level)) ? (w_r_in - r_fade_level) : '0;
            r_green     <= (r_s1_valid && (w_g_in > r_fade_level)) ? (w_g_in - r_fade_level) : '0;
            r_blue      <= (r_s1_valid && (w_b_in > r_fade_level)) ? (w_b_in - r_fade_level) : '0;
        end
    end

    // Double-buffered bank select; a request coinciding with frame_start wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending_bank <= '0;
            r_active_bank  <= '0;
        end else begin
            if (bank_req) begin
                r_pending_bank <= bank_sel;
            end
            if (frame_start) begin
                r_active_bank <= bank_req ? bank_sel : r_pending_bank;
            end
        end
    end

    // Control FSM: clear sweep, then frame-paced fade out/in with reversal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_init_addr  <= '0;
            r_init_done  <= 1'b0;
            r_fade_level <= '0;
            r_frame_cnt  <= '0;
            r_fade_done  <= 1'b0;
        end else begin
            r_fade_done <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_init_addr <= r_init_addr + ADDR_W'(1);
                    if (r_init_addr == C_ADDR_LAST) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (fade_out_req) begin
                        if (r_fade_level != C_LEVEL_MAX) begin
                            r_state     <= ST_FADE_OUT;
                            r_frame_cnt <= '0;
                        end else begin
                            r_fade_done <= 1'b1;
                        end
                    end else if (fade_in_req) begin
                        if (r_fade_level != '0) begin
                            r_state     <= ST_FADE_IN;
                            r_frame_cnt <= '0;
                        end else begin
                            r_fade_done <= 1'b1;
                        end
                    end
                end
                ST_FADE_OUT: begin
                    // Out has priority, so only a lone in-request reverses.
                    if (fade_in_req && !fade_out_req) begin
                        r_state     <= ST_FADE_IN;
                        r_frame_cnt <= '0;
                    end else if (w_step) begin
                        r_frame_cnt <= '0;
                        if (r_fade_level >= C_LEVEL_PEN) begin
                            r_fade_level <= C_LEVEL_MAX;
                            r_state      <= ST_IDLE;
                            r_fade_done  <= 1'b1;
                        end else begin
                            r_fade_level <= r_fade_level + CH_W'(1);
                        end
                    end else if (frame_start) begin
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    end
                end
                ST_FADE_IN: begin
                    if (fade_out_req) begin
                        r_state     <= ST_FADE_OUT;
                        r_frame_cnt <= '0;
                    end else if (w_step) begin
                        r_frame_cnt <= '0;
                        if (r_fade_level <= C_LEVEL_ONE) begin
                            r_fade_level <= '0;
                            r_state      <= ST_IDLE;
                            r_fade_done  <= 1'b1;
                        end else begin
                            r_fade_level <= r_fade_level - CH_W'(1);
                        end
                    end else if (frame_start) begin
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign rgb_valid   = r_rgb_valid;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign active_bank = r_active_bank;
    assign fade_level  = r_fade_level;
    assign fade_busy   = (r_state == ST_FADE_OUT) || (r_state == ST_FADE_IN);
    assign fade_done   = r_fade_done;
    assign init_done   = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_palette_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_palette_engine
// Description : Directed, scoreboard-checked bench for palette_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_engine;

    localparam int INDEX_W     = 6;
    localparam int CH_W        = 4;
    localparam int BANKS       = 2;
    localparam int BW          = 1;
    localparam int FADE_PERIOD = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame_start;
    logic               pix_valid;
    logic [INDEX_W-1:0] pix_index;
    logic               rgb_valid;
    logic [CH_W-1:0]    red;
    logic [CH_W-1:0]    green;
    logic [CH_W-1:0]    blue;
    logic               wr_en;
    logic [BW-1:0]      wr_bank;
    logic [INDEX_W-1:0] wr_index;
    logic [3*CH_W-1:0]  wr_rgb;
    logic               bank_req;
    logic [BW-1:0]      bank_sel;
    logic [BW-1:0]      active_bank;
    logic               fade_out_req;
    logic               fade_in_req;
    logic [CH_W-1:0]    fade_level;
    logic               fade_busy;
    logic               fade_done;
    logic               init_done;

    int total  = 0;
    int passed = 0;
    logic [11:0] sb[$];
    int run      = 0;
    int last_run = 0;

    palette_engine #(
        .INDEX_W     (INDEX_W),
        .CH_W        (CH_W),
        .BANKS       (BANKS),
        .FADE_PERIOD (FADE_PERIOD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_index    (pix_index),
        .rgb_valid    (rgb_valid),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_index     (wr_index),
        .wr_rgb       (wr_rgb),
        .bank_req     (bank_req),
        .bank_sel     (bank_sel),
        .active_bank  (active_bank),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .fade_level   (fade_level),
        .fade_busy    (fade_busy),
        .fade_done    (fade_done),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a colour.
    always @(negedge clk) begin
        if (rgb_valid) begin
            run++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL rgb_unexpected: got 0x%0h with no pending lookup", {red, green, blue});
            end else begin
                check("rgb", int'({red, green, blue}), int'(sb.pop_front()));
            end
        end else begin
            if (run != 0) last_run = run;
            run = 0;
            check("rgb_zero_when_invalid", int'({red, green, blue}), 0);
        end
    end

    task automatic wr(input int bank, input int idx, input logic [11:0] rgb);
        wr_en = 1'b1; wr_bank = bank[0]; wr_index = idx[5:0]; wr_rgb = rgb;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic lookup(input int idx, input logic [11:0] exp);
        pix_valid = 1'b1; pix_index = idx[5:0]; sb.push_back(exp);
        tick();
        pix_valid = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic stream(input logic [11:0] val5);
        last_run = 0;
        for (int i = 0; i < 64; i++) begin
            pix_valid = 1'b1; pix_index = i[5:0];
            sb.push_back((i == 5) ? val5 : 12'h000);
            tick();
        end
        pix_valid = 1'b0;
        tick(); tick(); tick();
        check("stream_no_bubbles", last_run, 64);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        end
    endtask

    // Last frame of a fade step: checks are taken right after its edge.
    task automatic step_frame(input int exp_level, input int exp_done, input int exp_busy);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("fade_level_step", fade_level, exp_level);
        check("fade_done_step", fade_done, exp_done);
        check("fade_busy_step", fade_busy, exp_busy);
        tick();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 300) begin
            if (n == 10) begin
                wr_en = 1'b1; wr_bank = 1'b0; wr_index = 6'd5; wr_rgb = 12'h777;
            end
            if (n == 20) begin
                pix_valid = 1'b1; pix_index = 6'd5;
            end
            tick();
            wr_en = 1'b0; pix_valid = 1'b0;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_index = '0;
        wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0;
        bank_req = 1'b0; bank_sel = '0; fade_out_req = 1'b0; fade_in_req = 1'b0;
        tick();
        reset = 1'b0;

        // Reset state and clear sweep length
        check("reset_init_done", init_done, 0);
        check("reset_fade_level", fade_level, 0);
        check("reset_active_bank", active_bank, 0);
        check("reset_rgb_valid", rgb_valid, 0);
        check("reset_fade_busy", fade_busy, 0);
        wait_init(n);
        check("init_sweep_cycles", n, 128);
        stream(12'h000);

        // Write then lookup on the next cycle: 2-cycle latency
        wr(0, 5, 12'hF84);
        pix_valid = 1'b1; pix_index = 6'd5; sb.push_back(12'hF84);
        tick();
        pix_valid = 1'b0;
        check("latency_cycle1_invalid", rgb_valid, 0);
        tick();
        check("latency_cycle2_valid", rgb_valid, 1);
        tick(); tick();
        stream(12'hF84);

        // Double-buffered bank switch
        wr(1, 5, 12'h123);
        bank_req = 1'b1; bank_sel = 1'b1; tick(); bank_req = 1'b0;
        check("bank_not_yet_switched", active_bank, 0);
        lookup(5, 12'hF84);
        frames(1);
        check("bank_switched_on_frame", active_bank, 1);
        lookup(5, 12'h123);
        wr_en = 1'b1; wr_bank = 1'b1; wr_index = 6'd5; wr_rgb = 12'hABC;
        pix_valid = 1'b1; pix_index = 6'd5; sb.push_back(12'h123);
        tick();
        wr_en = 1'b0; pix_valid = 1'b0;
        tick(); tick(); tick();
        lookup(5, 12'hABC);
        bank_req = 1'b1; bank_sel = 1'b0; tick();
        bank_sel = 1'b1; tick(); bank_req = 1'b0;
        frames(1);
        check("bank_last_request_wins", active_bank, 1);
        bank_req = 1'b1; bank_sel = 1'b0; frame_start = 1'b1; tick();
        bank_req = 1'b0; frame_start = 1'b0;
        check("bank_same_cycle_immediate", active_bank, 0);
        lookup(5, 12'hF84);

        // Fade out 0 -> 15, one step per 4 frames
        fade_out_req = 1'b1; tick(); fade_out_req = 1'b0;
        check("fade_out_busy", fade_busy, 1);
        for (int s = 1; s <= 15; s++) begin
            frames(3);
            check("fade_out_hold", fade_level, s - 1);
            step_frame(s, (s == 15) ? 1 : 0, (s == 15) ? 0 : 1);
            if (s == 4) lookup(5, 12'hB40);
        end
        check("fade_done_one_cycle", fade_done, 0);
        lookup(5, 12'h000);
        fade_out_req = 1'b1; tick(); fade_out_req = 1'b0;
        check("fade_out_at_max_done", fade_done, 1);
        check("fade_out_at_max_idle", fade_busy, 0);
        tick();
        check("fade_out_at_max_level", fade_level, 15);

        // Fade in 15 -> 0
        fade_in_req = 1'b1; tick(); fade_in_req = 1'b0;
        check("fade_in_busy", fade_busy, 1);
        for (int s = 14; s >= 0; s--) begin
            frames(3);
            step_frame(s, (s == 0) ? 1 : 0, (s == 0) ? 0 : 1);
        end
        fade_in_req = 1'b1; tick(); fade_in_req = 1'b0;
        check("fade_in_at_zero_done", fade_done, 1);
        check("fade_in_at_zero_idle", fade_busy, 0);
        tick();

        // Reversal at level 7 during fade out
        fade_out_req = 1'b1; tick(); fade_out_req = 1'b0;
        for (int s = 1; s <= 7; s++) frames(4);
        check("fade_out_reach_7", fade_level, 7);
        frames(2);
        fade_in_req = 1'b1; tick(); fade_in_req = 1'b0;
        check("reverse_busy", fade_busy, 1);
        frames(3);
        check("reverse_counter_cleared", fade_level, 7);
        step_frame(6, 0, 1);
        for (int s = 5; s >= 0; s--) begin
            frames(3);
            step_frame(s, (s == 0) ? 1 : 0, (s == 0) ? 0 : 1);
        end

        // Simultaneous requests at level 0: fade out wins
        fade_out_req = 1'b1; fade_in_req = 1'b1; tick();
        fade_out_req = 1'b0; fade_in_req = 1'b0;
        check("simul_busy", fade_busy, 1);
        frames(4);
        check("simul_went_out", fade_level, 1);

        // Reset mid-fade at level 9
        for (int s = 2; s <= 9; s++) frames(4);
        check("fade_reach_9", fade_level, 9);
        reset = 1'b1; tick(); reset = 1'b0;
        check("midfade_reset_level", fade_level, 0);
        check("midfade_reset_init_done", init_done, 0);
        check("midfade_reset_busy", fade_busy, 0);
        wait_init(n);
        check("reinit_sweep_cycles", n, 128);
        check("reinit_active_bank", active_bank, 0);
        lookup(5, 12'h000);
        lookup(63, 12'h000);

        tick(); tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
